// File: rtl/ring_mem_ingress.sv
// Ring-side ingress for the memory controller: token circulation with resend dumping,
// op and write-data queuing, round-robin local read arbitration and occupancy throttling.

module ring_mem_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign overflow = push && full;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // First-word fall-through: head is always mem[rd_ptr]; full pushes are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module ring_mem_ingress #(
    parameter int unsigned NUM_LOCAL       = 2,
    parameter int unsigned WORDS_PER_LINE  = 4,
    parameter int unsigned OPQ_DEPTH       = 32,
    parameter int unsigned WDQ_DEPTH       = 1024,
    parameter int unsigned WDQ_MARGIN      = 512,
    parameter int unsigned RSQ_DEPTH       = 64,
    parameter int unsigned LOCAL_DEST_BASE = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  ring_in,
    input  logic [3:0]                   slot_type_in,
    input  logic [3:0]                   source_in,
    output logic [31:0]                  ring_out,
    output logic [3:0]                   slot_type_out,
    output logic [3:0]                   source_out,
    input  logic                         inhibit,
    input  logic                         resend_wr,
    input  logic [39:0]                  resend_din,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic [3:0]                   op_dest,
    output logic [31:0]                  op_data,
    output logic                         wd_valid,
    input  logic                         wd_ready,
    output logic [32*WORDS_PER_LINE-1:0] wd_data,
    input  logic [NUM_LOCAL-1:0]         loc_req,
    input  logic [26*NUM_LOCAL-1:0]      loc_addr,
    output logic [NUM_LOCAL-1:0]         loc_ack,
    output logic [2:0]                   err_flags
);
    localparam logic [3:0]  SLOT_NULL  = 4'h0;
    localparam logic [3:0]  SLOT_TOKEN = 4'h1;
    localparam logic [3:0]  SLOT_ADDR  = 4'h2;
    localparam logic [3:0]  SLOT_WDATA = 4'h3;

    localparam int unsigned LINE_W = 32 * WORDS_PER_LINE;
    localparam int unsigned CNT_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned PTR_W  = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;
    localparam int unsigned OPQ_CW = $clog2(OPQ_DEPTH) + 1;
    localparam int unsigned WDQ_CW = $clog2(WDQ_DEPTH) + 1;
    localparam int unsigned RSQ_CW = $clog2(RSQ_DEPTH) + 1;
    localparam int unsigned WDQ_AF = WDQ_DEPTH - WDQ_MARGIN;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DUMP       = 2'd1,
        WAIT_TOKEN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              go;
    logic              addr_slot;

    logic [RSQ_CW-1:0] rsq_count;
    logic              rsq_empty;
    logic              rsq_pop;
    logic [39:0]       rsq_head;
    logic              rsq_ovf;

    logic [OPQ_CW-1:0] opq_count;
    logic              opq_full;
    logic              opq_push;
    logic [35:0]       opq_din;
    logic [35:0]       opq_head;
    logic              opq_ovf;

    logic [WDQ_CW-1:0] wdq_count;
    logic              wdq_almost_full;
    logic [LINE_W-1:0] wdq_din;
    logic [LINE_W-1:0] wdq_head;
    logic              wdq_ovf;

    logic [31:0]       words [WORDS_PER_LINE];
    logic [CNT_W-1:0]  word_cnt;
    logic              line_pend;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic              loc_sel;

    assign addr_slot       = (slot_type_in == SLOT_ADDR);
    assign rsq_empty       = (rsq_count == '0);
    assign opq_full        = (opq_count == OPQ_CW'(OPQ_DEPTH));
    assign wdq_almost_full = (wdq_count >= WDQ_CW'(WDQ_AF));
    assign go              = !inhibit && !wdq_almost_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the combinational ring output and resend pop.
    always_comb begin
        state_next    = state;
        rsq_pop       = 1'b0;
        ring_out      = ring_in;
        slot_type_out = slot_type_in;
        source_out    = source_in;
        case (state)
            IDLE:       if (go) state_next = DUMP;
            DUMP:       if (rsq_empty) state_next = WAIT_TOKEN;
            WAIT_TOKEN: if (slot_type_in == SLOT_TOKEN) state_next = go ? DUMP : IDLE;
            default:    state_next = IDLE;
        endcase
        if (state == DUMP && rsq_empty) begin
            ring_out      = '0;
            slot_type_out = SLOT_TOKEN;
            source_out    = '0;
        end else if (state == DUMP) begin
            {source_out, slot_type_out, ring_out} = rsq_head;
            rsq_pop = 1'b1;
        end else if (slot_type_in == SLOT_TOKEN || source_in == 4'h0 ||
                     (addr_slot && ring_in[31])) begin
            ring_out      = '0;
            slot_type_out = SLOT_NULL;
            source_out    = '0;
        end
    end

    // Lowest requesting index at or after the round-robin pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < int'(NUM_LOCAL); k++) begin
            if (!grant_any && loc_req[PTR_W'((int'(rr_ptr) + k) % int'(NUM_LOCAL))]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'((int'(rr_ptr) + k) % int'(NUM_LOCAL));
            end
        end
    end

    assign loc_sel  = grant_any && !addr_slot && !opq_full;
    assign opq_push = addr_slot || loc_sel;

    always_comb begin
        loc_ack = '0;
        if (loc_sel) begin
            loc_ack[grant_idx] = 1'b1;
        end
        if (addr_slot) begin
            opq_din = {source_in, ring_in};
        end else begin
            opq_din = {4'(LOCAL_DEST_BASE + 32'(grant_idx)), 6'b000100,
                       loc_addr[26*int'(grant_idx) +: 26]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (loc_sel) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_LOCAL - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Line assembly; the completed line is pushed the cycle after its last word.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_cnt  <= '0;
            line_pend <= 1'b0;
        end else begin
            line_pend <= 1'b0;
            if (slot_type_in == SLOT_WDATA) begin
                word_cnt  <= word_cnt + CNT_W'(1);
                line_pend <= (word_cnt == CNT_W'(WORDS_PER_LINE - 1));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (slot_type_in == SLOT_WDATA) begin
            words[word_cnt] <= ring_in;
        end
    end

    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
        assign wdq_din[32*g +: 32] = words[g];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_flags <= '0;
        end else begin
            err_flags <= err_flags | {rsq_ovf, wdq_ovf, opq_ovf};
        end
    end

    ring_mem_fifo #(.WIDTH(40), .DEPTH(RSQ_DEPTH)) u_rsq (
        .clock    (clock),
        .reset    (reset),
        .push     (resend_wr),
        .din      (resend_din),
        .pop      (rsq_pop),
        .dout     (rsq_head),
        .count    (rsq_count),
        .overflow (rsq_ovf)
    );

    ring_mem_fifo #(.WIDTH(36), .DEPTH(OPQ_DEPTH)) u_opq (
        .clock    (clock),
        .reset    (reset),
        .push     (opq_push),
        .din      (opq_din),
        .pop      (op_ready),
        .dout     (opq_head),
        .count    (opq_count),
        .overflow (opq_ovf)
    );

    ring_mem_fifo #(.WIDTH(LINE_W), .DEPTH(WDQ_DEPTH)) u_wdq (
        .clock    (clock),
        .reset    (reset),
        .push     (line_pend),
        .din      (wdq_din),
        .pop      (wd_ready),
        .dout     (wdq_head),
        .count    (wdq_count),
        .overflow (wdq_ovf)
    );

    assign op_valid = (opq_count != '0);
    assign op_dest  = opq_head[35:32];
    assign op_data  = opq_head[31:0];
    assign wd_valid = (wdq_count != '0);
    assign wd_data  = wdq_head;
endmodule

// File: tb/tb_ring_mem_ingress.sv
// Directed bench for ring_mem_ingress: token flow, resend dump, arbitration, line assembly, throttling, overflow.

module tb_ring_mem_ingress;
    localparam logic [3:0] SLOT_NULL  = 4'h0;
    localparam logic [3:0] SLOT_TOKEN = 4'h1;
    localparam logic [3:0] SLOT_ADDR  = 4'h2;
    localparam logic [3:0] SLOT_WDATA = 4'h3;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  ring_in;
    logic [3:0]   slot_type_in;
    logic [3:0]   source_in;
    logic [31:0]  ring_out;
    logic [3:0]   slot_type_out;
    logic [3:0]   source_out;
    logic         inhibit;
    logic         resend_wr;
    logic [39:0]  resend_din;
    logic         op_valid;
    logic         op_ready;
    logic [3:0]   op_dest;
    logic [31:0]  op_data;
    logic         wd_valid;
    logic         wd_ready;
    logic [127:0] wd_data;
    logic [1:0]   loc_req;
    logic [51:0]  loc_addr;
    logic [1:0]   loc_ack;
    logic [2:0]   err_flags;

    int total = 0;
    int bad   = 0;

    ring_mem_ingress dut (
        .clock         (clock),
        .reset         (reset),
        .ring_in       (ring_in),
        .slot_type_in  (slot_type_in),
        .source_in     (source_in),
        .ring_out      (ring_out),
        .slot_type_out (slot_type_out),
        .source_out    (source_out),
        .inhibit       (inhibit),
        .resend_wr     (resend_wr),
        .resend_din    (resend_din),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_dest       (op_dest),
        .op_data       (op_data),
        .wd_valid      (wd_valid),
        .wd_ready      (wd_ready),
        .wd_data       (wd_data),
        .loc_req       (loc_req),
        .loc_addr      (loc_addr),
        .loc_ack       (loc_ack),
        .err_flags     (err_flags)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        slot_type_in = SLOT_NULL;
        source_in    = 4'h0;
        ring_in      = 32'h0;
        resend_wr    = 1'b0;
        resend_din   = 40'h0;
        loc_req      = 2'b00;
    endtask

    task automatic test_reset();
        logic seen;
        idle_inputs();
        op_ready = 1'b0;
        wd_ready = 1'b0;
        loc_addr = '0;
        inhibit  = 1'b0;
        reset    = 1'b1;
        tick();
        total++;
        if ({op_valid, wd_valid, err_flags, loc_ack} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000", {op_valid, wd_valid, err_flags, loc_ack});
        end
        reset = 1'b0;
        #1;
        total++;
        if (slot_type_out !== SLOT_NULL) begin
            bad++;
            $display("FAIL idle_no_token: got %h want %h", slot_type_out, SLOT_NULL);
        end
        tick();
        total++;
        if ({slot_type_out, source_out, ring_out} !== {SLOT_TOKEN, 4'h0, 32'h0}) begin
            bad++;
            $display("FAIL first_token: got %h/%h/%h want 1/0/0", slot_type_out, source_out, ring_out);
        end
        tick();
        slot_type_in = 4'h5;
        source_in    = 4'h2;
        ring_in      = 32'hCAFE_0001;
        #1;
        total++;
        if ({slot_type_out, source_out, ring_out} !== {4'h5, 4'h2, 32'hCAFE_0001}) begin
            bad++;
            $display("FAIL passthrough: got %h/%h/%h want 5/2/cafe0001", slot_type_out, source_out, ring_out);
        end
        slot_type_in = SLOT_TOKEN;
        source_in    = 4'h1;
        ring_in      = 32'h0;
        #1;
        total++;
        if ({slot_type_out, source_out, ring_out} !== {SLOT_NULL, 4'h0, 32'h0}) begin
            bad++;
            $display("FAIL token_absorbed: got %h/%h/%h want 0/0/0", slot_type_out, source_out, ring_out);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (slot_type_out !== SLOT_TOKEN) begin
            bad++;
            $display("FAIL token_reissued: got %h want %h", slot_type_out, SLOT_TOKEN);
        end
        tick();
        inhibit      = 1'b1;
        slot_type_in = SLOT_TOKEN;
        source_in    = 4'h1;
        tick();
        idle_inputs();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (slot_type_out === SLOT_TOKEN) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL inhibit_holds_token: got token=%b want 0", seen);
        end
    endtask

    task automatic test_resend();
        for (int i = 0; i < 3; i++) begin
            resend_wr  = 1'b1;
            resend_din = {4'h5, SLOT_ADDR, 32'(32'h100 + i)};
            tick();
        end
        resend_wr = 1'b0;
        inhibit   = 1'b0;
        #1;
        total++;
        if (slot_type_out !== SLOT_NULL) begin
            bad++;
            $display("FAIL resend_idle: got %h want %h", slot_type_out, SLOT_NULL);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({slot_type_out, ring_out, source_out} !== {SLOT_ADDR, 32'(32'h100 + i), 4'h5}) begin
                bad++;
                $display("FAIL resend_emit%0d: got %h/%h/%h want 2/%h/5", i, slot_type_out, ring_out,
                         source_out, 32'(32'h100 + i));
            end
            tick();
        end
        total++;
        if ({slot_type_out, ring_out, source_out} !== {SLOT_TOKEN, 32'h0, 4'h0}) begin
            bad++;
            $display("FAIL resend_then_token: got %h/%h/%h want 1/0/0", slot_type_out, ring_out, source_out);
        end
        tick();
    endtask

    task automatic test_arbitration();
        logic [35:0] exp_ops [3];
        exp_ops[0] = {4'h3, 32'h0000_1234};
        exp_ops[1] = {4'h0, 32'h1000_0111};
        exp_ops[2] = {4'h1, 32'h1000_0222};
        loc_addr     = {26'h0000222, 26'h0000111};
        slot_type_in = SLOT_ADDR;
        source_in    = 4'h3;
        ring_in      = 32'h0000_1234;
        loc_req      = 2'b11;
        #1;
        total++;
        if (loc_ack !== 2'b00) begin
            bad++;
            $display("FAIL ack_blocked_by_addr: got %b want 00", loc_ack);
        end
        tick();
        slot_type_in = SLOT_NULL;
        source_in    = 4'h0;
        ring_in      = 32'h0;
        #1;
        total++;
        if ({op_valid, op_dest, op_data} !== {1'b1, exp_ops[0]}) begin
            bad++;
            $display("FAIL addr_op_latency: got %b/%h/%h want 1/3/00001234", op_valid, op_dest, op_data);
        end
        total++;
        if (loc_ack !== 2'b01) begin
            bad++;
            $display("FAIL ack_req0: got %b want 01", loc_ack);
        end
        tick();
        loc_req = 2'b10;
        #1;
        total++;
        if (loc_ack !== 2'b10) begin
            bad++;
            $display("FAIL ack_req1: got %b want 10", loc_ack);
        end
        tick();
        loc_req  = 2'b00;
        op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({op_valid, op_dest, op_data} !== {1'b1, exp_ops[i]}) begin
                bad++;
                $display("FAIL op_order%0d: got %b/%h/%h want 1/%h", i, op_valid, op_dest, op_data, exp_ops[i]);
            end
            tick();
        end
        op_ready = 1'b0;
        #1;
        total++;
        if (op_valid !== 1'b0) begin
            bad++;
            $display("FAIL op_drained: got %b want 0", op_valid);
        end
    endtask

    task automatic test_wdata();
        source_in = 4'h2;
        for (int i = 0; i < 4; i++) begin
            slot_type_in = SLOT_WDATA;
            ring_in      = 32'(32'hA + i);
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if (wd_valid !== 1'b0) begin
            bad++;
            $display("FAIL wd_not_early: got %b want 0", wd_valid);
        end
        tick();
        total++;
        if ({wd_valid, wd_data} !== {1'b1, 128'h0000000D_0000000C_0000000B_0000000A}) begin
            bad++;
            $display("FAIL wd_line: got %b/%h want 1/0000000d0000000c0000000b0000000a", wd_valid, wd_data);
        end
        wd_ready = 1'b1;
        tick();
        wd_ready = 1'b0;
        #1;
        total++;
        if (wd_valid !== 1'b0) begin
            bad++;
            $display("FAIL wd_popped: got %b want 0", wd_valid);
        end
        source_in    = 4'h2;
        slot_type_in = SLOT_WDATA;
        ring_in      = 32'h11;
        tick();
        ring_in = 32'h22;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        source_in = 4'h2;
        for (int i = 0; i < 4; i++) begin
            slot_type_in = SLOT_WDATA;
            ring_in      = 32'(32'h31 + i);
            tick();
        end
        idle_inputs();
        tick();
        total++;
        if ({wd_valid, wd_data} !== {1'b1, 128'h00000034_00000033_00000032_00000031}) begin
            bad++;
            $display("FAIL wd_after_reset: got %b/%h want 1/00000034000000330000003200000031", wd_valid, wd_data);
        end
        wd_ready = 1'b1;
        tick();
        wd_ready = 1'b0;
        #1;
        total++;
        if (wd_valid !== 1'b0) begin
            bad++;
            $display("FAIL wd_single_line: got %b want 0", wd_valid);
        end
    endtask

    task automatic test_throttle();
        logic seen;
        source_in = 4'h2;
        for (int i = 0; i < 2048; i++) begin
            slot_type_in = SLOT_WDATA;
            ring_in      = 32'(i);
            tick();
        end
        idle_inputs();
        tick();
        slot_type_in = SLOT_TOKEN;
        source_in    = 4'h1;
        tick();
        idle_inputs();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (slot_type_out === SLOT_TOKEN) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL wdq_full_withholds: got token=%b want 0", seen);
        end
        total++;
        if ({wd_valid, wd_data} !== {1'b1, 128'h00000003_00000002_00000001_00000000}) begin
            bad++;
            $display("FAIL wdq_head: got %b/%h want 1/00000003000000020000000100000000", wd_valid, wd_data);
        end
        wd_ready = 1'b1;
        tick();
        wd_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            #1;
            if (slot_type_out === SLOT_TOKEN) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL token_resumes: got token=%b want 1", seen);
        end
    endtask

    task automatic test_nullify();
        slot_type_in = 4'h5;
        source_in    = 4'h0;
        ring_in      = 32'h55;
        #1;
        total++;
        if ({slot_type_out, source_out, ring_out} !== {SLOT_NULL, 4'h0, 32'h0}) begin
            bad++;
            $display("FAIL null_src0: got %h/%h/%h want 0/0/0", slot_type_out, source_out, ring_out);
        end
        slot_type_in = SLOT_ADDR;
        source_in    = 4'h2;
        ring_in      = 32'h8000_0001;
        #1;
        total++;
        if ({slot_type_out, source_out, ring_out} !== {SLOT_NULL, 4'h0, 32'h0}) begin
            bad++;
            $display("FAIL null_addr_bit31: got %h/%h/%h want 0/0/0", slot_type_out, source_out, ring_out);
        end
        ring_in = 32'h0000_0042;
        #1;
        total++;
        if ({slot_type_out, source_out, ring_out} !== {SLOT_ADDR, 4'h2, 32'h42}) begin
            bad++;
            $display("FAIL addr_pass: got %h/%h/%h want 2/2/00000042", slot_type_out, source_out, ring_out);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_opq_overflow();
        int          n;
        logic [31:0] first_data;
        logic [31:0] last_data;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            slot_type_in = SLOT_ADDR;
            source_in    = 4'h4;
            ring_in      = 32'(i);
            tick();
        end
        total++;
        if ({op_valid, err_flags} !== 4'b1000) begin
            bad++;
            $display("FAIL opq_exact_full: got %b/%b want 1/000", op_valid, err_flags);
        end
        ring_in  = 32'h0000_FFFF;
        loc_req  = 2'b01;
        loc_addr = {26'h0000222, 26'h0000111};
        tick();
        slot_type_in = SLOT_NULL;
        source_in    = 4'h0;
        ring_in      = 32'h0;
        #1;
        total++;
        if (err_flags !== 3'b001) begin
            bad++;
            $display("FAIL opq_overflow_flag: got %b want 001", err_flags);
        end
        total++;
        if (loc_ack !== 2'b00) begin
            bad++;
            $display("FAIL ack_while_full: got %b want 00", loc_ack);
        end
        tick();
        loc_req    = 2'b00;
        op_ready   = 1'b1;
        n          = 0;
        first_data = 32'hDEAD_BEEF;
        last_data  = 32'hDEAD_BEEF;
        while (op_valid && n < 40) begin
            if (n == 0) first_data = op_data;
            last_data = op_data;
            n++;
            tick();
        end
        op_ready = 1'b0;
        total++;
        if ({n, first_data, last_data} !== {32'd32, 32'd0, 32'd31}) begin
            bad++;
            $display("FAIL opq_contents: got n=%0d first=%h last=%h want 32/0/1f", n, first_data, last_data);
        end
        total++;
        if (err_flags !== 3'b001) begin
            bad++;
            $display("FAIL opq_flag_sticky: got %b want 001", err_flags);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_resend();
        test_arbitration();
        test_wdata();
        test_throttle();
        test_nullify();
        test_opq_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
